// File: rtl/add_and_cmp_unit.sv
// Single-cycle ADD / AND / CMP unit that registers its result and NZCV flags.
// Optional build macro ADD_SATURATE_EN makes ADD saturate on signed overflow.
module add_and_cmp_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  logic             s,
    input  logic [3:0]       flag,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       new_flag,
    output logic             out_valid
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] and_res;
    logic             add_v;
    logic             cmp_v;
    logic [WIDTH-1:0] res_next;
    logic [3:0]       flag_next;

    // Subtraction is reg1 + ~reg2 + 1 so its carry-out means "no borrow".
    assign sum_ext  = {1'b0, reg1} + {1'b0, reg2};
    assign diff_ext = {1'b0, reg1} + {1'b0, ~reg2} + {{WIDTH{1'b0}}, 1'b1};
    assign sum      = sum_ext[WIDTH-1:0];
    assign diff     = diff_ext[WIDTH-1:0];
    assign and_res  = reg1 & reg2;

    assign add_v = (reg1[WIDTH-1] == reg2[WIDTH-1]) && (sum[WIDTH-1] != reg1[WIDTH-1]);
    assign cmp_v = (reg1[WIDTH-1] != reg2[WIDTH-1]) && (diff[WIDTH-1] != reg1[WIDTH-1]);

`ifdef ADD_SATURATE_EN
    assign add_res = add_v ? (reg1[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum;
`else
    assign add_res = sum;
`endif

    always_comb begin
        res_next  = result;
        flag_next = flag;
        case (op)
            OP_ADD: begin
                res_next = add_res;
                if (s)
                    flag_next = {add_res[WIDTH-1], add_res == '0, sum_ext[WIDTH], add_v};
            end
            OP_AND: begin
                res_next = and_res;
                if (s)
                    flag_next = {and_res[WIDTH-1], and_res == '0, flag[1:0]};
            end
            OP_CMP: begin
                flag_next = {diff[WIDTH-1], diff == '0, diff_ext[WIDTH], cmp_v};
            end
            default: begin
                res_next  = result;
                flag_next = flag;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            new_flag  <= 4'b0000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= res_next;
                new_flag <= flag_next;
            end
        end
    end

endmodule

// File: tb/tb_add_and_cmp_unit.sv
// Directed self-checking bench for add_and_cmp_unit; expectations follow ADD_SATURATE_EN if defined.
module tb_add_and_cmp_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        s;
    logic [3:0]  flag;
    logic [31:0] result;
    logic [3:0]  new_flag;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    add_and_cmp_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op),
        .reg1(reg1), .reg2(reg2), .s(s), .flag(flag),
        .result(result), .new_flag(new_flag), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Present one request for exactly one rising edge, then sample 1 time unit later.
    task automatic drive(input logic v, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic sv, input logic [3:0] f);
        @(negedge clk);
        in_valid = v; op = o; reg1 = a; reg2 = b; s = sv; flag = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; op = 2'b00; reg1 = '0; reg2 = '0; s = 1'b0; flag = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (result !== 32'h0 || new_flag !== 4'b0000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got res=%h flg=%b ov=%b exp res=00000000 flg=0000 ov=0",
                     result, new_flag, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
`ifdef ADD_SATURATE_EN
        exp_r = 32'h7FFFFFFF; exp_f = 4'b0001;
`else
        exp_r = 32'h80000000; exp_f = 4'b1001;
`endif
        drive(1'b1, 2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b1, 4'b0000);
        n_checks++;
        if (result !== exp_r || new_flag !== exp_f || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL add_overflow got res=%h flg=%b ov=%b exp res=%h flg=%b ov=1",
                     result, new_flag, out_valid, exp_r, exp_f);
        end
        drive(1'b1, 2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b1, 4'b0000);
        n_checks++;
        if (result !== 32'h0 || new_flag !== 4'b0110) begin
            n_fail++;
            $display("FAIL add_carry_zero got res=%h flg=%b exp res=00000000 flg=0110", result, new_flag);
        end
        drive(1'b1, 2'b00, 32'h00000007, 32'h00000009, 1'b0, 4'b1010);
        n_checks++;
        if (result !== 32'h00000010 || new_flag !== 4'b1010) begin
            n_fail++;
            $display("FAIL add_s0_keep_flags got res=%h flg=%b exp res=00000010 flg=1010", result, new_flag);
        end
        drive(1'b1, 2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0, 4'b1010);
        n_checks++;
        if (result !== 32'h0 || new_flag !== 4'b1010) begin
            n_fail++;
            $display("FAIL add_s0_wrap got res=%h flg=%b exp res=00000000 flg=1010", result, new_flag);
        end
`ifdef ADD_SATURATE_EN
        exp_r = 32'h80000000; exp_f = 4'b1011;
`else
        exp_r = 32'h7FFFFFFF; exp_f = 4'b0011;
`endif
        drive(1'b1, 2'b00, 32'h80000000, 32'hFFFFFFFF, 1'b1, 4'b0000);
        n_checks++;
        if (result !== exp_r || new_flag !== exp_f) begin
            n_fail++;
            $display("FAIL add_neg_overflow got res=%h flg=%b exp res=%h flg=%b", result, new_flag, exp_r, exp_f);
        end
    endtask

    task automatic test_and();
        drive(1'b1, 2'b01, 32'hF0F00000, 32'h0F0F0000, 1'b1, 4'b0011);
        n_checks++;
        if (result !== 32'h0 || new_flag !== 4'b0111) begin
            n_fail++;
            $display("FAIL and_zero got res=%h flg=%b exp res=00000000 flg=0111", result, new_flag);
        end
        drive(1'b1, 2'b01, 32'hFF00FF00, 32'hF0F0F0F0, 1'b1, 4'b0100);
        n_checks++;
        if (result !== 32'hF000F000 || new_flag !== 4'b1000) begin
            n_fail++;
            $display("FAIL and_neg got res=%h flg=%b exp res=f000f000 flg=1000", result, new_flag);
        end
        drive(1'b1, 2'b01, 32'h0000FFFF, 32'h12345678, 1'b0, 4'b0110);
        n_checks++;
        if (result !== 32'h00005678 || new_flag !== 4'b0110) begin
            n_fail++;
            $display("FAIL and_s0 got res=%h flg=%b exp res=00005678 flg=0110", result, new_flag);
        end
    endtask

    task automatic test_cmp();
        drive(1'b1, 2'b00, 32'h12340000, 32'h00005678, 1'b0, 4'b0000);
        drive(1'b1, 2'b10, 32'd5, 32'd5, 1'b0, 4'b0000);
        n_checks++;
        if (result !== 32'h12345678 || new_flag !== 4'b0110 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL cmp_equal got res=%h flg=%b ov=%b exp res=12345678 flg=0110 ov=1",
                     result, new_flag, out_valid);
        end
        drive(1'b1, 2'b10, 32'd3, 32'd5, 1'b0, 4'b0111);
        n_checks++;
        if (result !== 32'h12345678 || new_flag !== 4'b1000) begin
            n_fail++;
            $display("FAIL cmp_less got res=%h flg=%b exp res=12345678 flg=1000", result, new_flag);
        end
        drive(1'b1, 2'b10, 32'h80000000, 32'h00000001, 1'b0, 4'b0000);
        n_checks++;
        if (new_flag !== 4'b0011) begin
            n_fail++;
            $display("FAIL cmp_overflow got flg=%b exp flg=0011", new_flag);
        end
    endtask

    task automatic test_reserved();
        drive(1'b1, 2'b11, 32'hDEADBEEF, 32'h1, 1'b1, 4'b1101);
        n_checks++;
        if (result !== 32'h12345678 || new_flag !== 4'b1101 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_op got res=%h flg=%b ov=%b exp res=12345678 flg=1101 ov=1",
                     result, new_flag, out_valid);
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 2'b00, 32'h1, 32'h1, 1'b1, 4'b0000);
        n_checks++;
        if (result !== 32'h12345678 || new_flag !== 4'b1101 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold got res=%h flg=%b ov=%b exp res=12345678 flg=1101 ov=0",
                     result, new_flag, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
        drive(1'b1, 2'b00, 32'd1, 32'd2, 1'b1, 4'b0000);
        n_checks++;
        if (result !== 32'd3 || new_flag !== 4'b0000 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first got res=%h flg=%b ov=%b exp res=00000003 flg=0000 ov=1",
                     result, new_flag, out_valid);
        end
        drive(1'b1, 2'b00, 32'd10, 32'd20, 1'b1, 4'b0000);
        n_checks++;
        if (result !== 32'd30 || new_flag !== 4'b0000 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second got res=%h flg=%b ov=%b exp res=0000001e flg=0000 ov=1",
                     result, new_flag, out_valid);
        end
`ifdef ADD_SATURATE_EN
        exp_r = 32'h80000000; exp_f = 4'b1011;
`else
        exp_r = 32'h00000000; exp_f = 4'b0111;
`endif
        drive(1'b1, 2'b00, 32'h80000000, 32'h80000000, 1'b1, 4'b0000);
        n_checks++;
        if (result !== exp_r || new_flag !== exp_f || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_third got res=%h flg=%b ov=%b exp res=%h flg=%b ov=1",
                     result, new_flag, out_valid, exp_r, exp_f);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== exp_r) begin
            n_fail++;
            $display("FAIL b2b_pulse_end got ov=%b res=%h exp ov=0 res=%h", out_valid, result, exp_r);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 2'b00, 32'd100, 32'd200, 1'b1, 4'b1111);
        n_checks++;
        if (result !== 32'h0 || new_flag !== 4'b0000 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority got res=%h flg=%b ov=%b exp res=00000000 flg=0000 ov=0",
                     result, new_flag, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 2'b00, 32'd100, 32'd200, 1'b1, 4'b1111);
        n_checks++;
        if (result !== 32'd300 || new_flag !== 4'b0000 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_accept got res=%h flg=%b ov=%b exp res=0000012c flg=0000 ov=1",
                     result, new_flag, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_and();
        test_cmp();
        test_reserved();
        test_hold();
        test_back_to_back();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_and_cmp_unit.md
ADD_AND_CMP_UNIT -- requirements
Module: add_and_cmp_unit

Interface
- REQ-001: Parameter WIDTH, default 32, operand and result width in bits; only 32 is required to be supported.
- REQ-002: clk, input, 1 bit, single clock; all state updates on its rising edge.
- REQ-003: rst, input, 1 bit, reset is synchronous and active-high.
- REQ-004: in_valid, input, 1 bit, operation request qualifier, sampled on the rising edge of clk.
- REQ-005: op, input, 2 bits, operation select: 00 ADD, 01 AND, 10 CMP, 11 reserved.
- REQ-006: reg1, input, WIDTH bits, operand A, two's-complement.
- REQ-007: reg2, input, WIDTH bits, operand B, two's-complement.
- REQ-008: s, input, 1 bit, flag-update enable for ADD and AND.
- REQ-009: flag, input, 4 bits, current flags, bit order [3]=N, [2]=Z, [1]=C, [0]=V.
- REQ-010: result, output, WIDTH bits, registered operation result.
- REQ-011: new_flag, output, 4 bits, registered updated flags, same bit order as flag.
- REQ-012: out_valid, output, 1 bit, one-cycle pulse marking new result/new_flag.

Function
- REQ-013: When in_valid=1 at a rising edge (rst=0), the unit SHALL register result, new_flag and out_valid=1 on that edge; latency is 1 cycle.
- REQ-014: When in_valid=0, result and new_flag SHALL hold and out_valid SHALL be 0.
- REQ-015: ADD: sum = reg1 + reg2, modulo 2^WIDTH. C SHALL be the carry-out. V SHALL be set when reg1 and reg2 share a sign and the sum's sign differs.
- REQ-016: ADD: N SHALL be result[WIDTH-1] and Z SHALL be (result==0), taken from the value written to result.
- REQ-017: AND: result SHALL be reg1 & reg2. N and Z SHALL be taken from result. C and V SHALL be copied from flag.
- REQ-018: For ADD and AND with s=0, new_flag SHALL equal flag while result still updates.
- REQ-019: CMP SHALL compute reg1 + ~reg2 + 1 and always update all four flags, ignoring s.
- REQ-020: CMP flags: N = difference MSB; Z = (difference==0); C = carry-out (1 when reg1 >= reg2 unsigned); V = signed subtraction overflow.
- REQ-021: CMP SHALL leave result unchanged.
- REQ-022: op=11 SHALL leave result unchanged, set new_flag = flag, and still pulse out_valid.
- REQ-023: Back-to-back requests SHALL be accepted every cycle, each producing its own out_valid pulse.
- REQ-024: The unit SHALL perform no input-side handshake and have no stall; every valid request is accepted.

Reset
- REQ-025: While rst=1 at a rising edge: result=0, new_flag=4'b0000, out_valid=0.
- REQ-026: rst SHALL take priority over in_valid; a request presented in the same cycle as rst is discarded.
- REQ-027: The first cycle after rst deasserts SHALL accept requests normally.

Configuration
- REQ-028: Macro ADD_SATURATE_EN.
  - Defined: ADD on signed overflow SHALL write 0x7FFFFFFF when reg1 is non-negative, else 0x80000000. N and Z SHALL come from the saturated value. V=1. C = raw carry.
  - Undefined: ADD SHALL wrap modulo 2^WIDTH.
  - AND and CMP are unaffected by the macro.

Verification
- REQ-029: ADD 0x7FFFFFFF+0x00000001, s=1 -> result 0x80000000, new_flag 1001 without the macro; result 0x7FFFFFFF, new_flag 0001 with the macro.
- REQ-030: ADD 0xFFFFFFFF+0x00000001, s=1 -> result 0x00000000, new_flag 0110; same operands with s=0 and flag 1010 -> new_flag 1010.
- REQ-031: AND 0xF0F00000 & 0x0F0F0000, s=1, flag 0011 -> result 0x00000000, new_flag 0111.
- REQ-032: CMP 5 vs 5, s=0, previous result 0x12345678 -> new_flag 0110, result stays 0x12345678. CMP 3 vs 5 -> new_flag 1000.
- REQ-033: rst=1 with in_valid=1 -> next cycle result 0, new_flag 0000, out_valid 0. Three back-to-back ADDs -> three consecutive out_valid pulses, each carrying its own correct result.
